// File: rtl/fec_pkg.sv
// Shared types and GF(2)[x]/(x^W-1) helpers for the streaming FEC matrix block.
// The rotation and popcount helpers are width-parametrised through a class
// with static functions so every user picks its own symbol width.
package fec_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DRAIN = 2'd2
    } fec_state_e;

    class fec_math #(parameter int W = 11);

        static function int popcount(input logic [W-1:0] x);
            int n;
            n = 0;
            for (int i = 0; i < W; i++) begin
                n += int'(x[i]);
            end
            return n;
        endfunction

        // Multiplication by x^sh in the cyclic ring is a left rotation.
        static function logic [W-1:0] rotl(input logic [W-1:0] x, input int sh);
            if (sh == 0) begin
                return x;
            end
            return (x << sh) | (x >> (W - sh));
        endfunction

        // Dense masks are replaced by their complement before use.
        static function logic needs_complement(input logic [W-1:0] mask);
            return popcount(mask) > ((W - 1) / 2);
        endfunction

    endclass

endpackage

// File: rtl/fec_coeff_apply.sv
// Combinational single coefficient x symbol product in the cyclic-shift code.
module fec_coeff_apply
    import fec_pkg::*;
#(
    parameter int W = 11
) (
    input  logic [W-1:0] mask,
    input  logic [W-1:0] symbol,
    output logic [W-1:0] result
);

    logic [W-1:0] adj;

    // Complement-threshold the mask, then XOR the rotations selected by its bits.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path can infer a latch.
        adj    = fec_math#(W)::needs_complement(mask) ? ~mask : mask;
        result = '0;
        if (mask != '0) begin
            for (int i = 0; i < W; i++) begin
                if (adj[i]) begin
                    result = result ^ fec_math#(W)::rotl(symbol, i);
                end
            end
        end
    end

endmodule

// File: rtl/fec_matrix_stream.sv
// Streaming FEC matrix multiplier: COLS source symbols in, ROWS coded symbols out.
// Optional feature macro FEC_COEFF_SHADOW_EN adds a shadow coefficient bank with
// a commit request; without it the single bank is written only while idle.
module fec_matrix_stream
    import fec_pkg::*;
#(
    parameter  int ROWS = 3,
    parameter  int COLS = 3,
    parameter  int W    = 11,
    localparam int RW   = (ROWS > 1) ? $clog2(ROWS) : 1,
    localparam int CW   = (COLS > 1) ? $clog2(COLS) : 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          cfg_we,
    output logic          cfg_ready,
    input  logic [RW-1:0] cfg_row,
    input  logic [CW-1:0] cfg_col,
    input  logic [W-1:0]  cfg_coeff,
    input  logic          cfg_commit,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [W-1:0]  in_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [W-1:0]  out_data,
    output logic [RW-1:0] out_row,
    output logic          out_last
);

    localparam logic [RW-1:0] ROW_LAST = RW'(ROWS - 1);
    localparam logic [CW-1:0] COL_LAST = CW'(COLS - 1);

    fec_state_e    state, next_state;
    logic [CW-1:0] col;
    logic [RW-1:0] row;
    logic [W-1:0]  acc   [ROWS];
    logic [W-1:0]  coeff [ROWS][COLS];
    logic [W-1:0]  prod  [ROWS];
    logic          in_fire, out_fire, cfg_hit;

    assign in_ready  = (state != DRAIN);
    assign out_valid = (state == DRAIN);
    assign in_fire   = in_valid && in_ready;
    assign out_fire  = out_valid && out_ready;
    assign cfg_hit   = cfg_we && (int'(cfg_row) < ROWS) && (int'(cfg_col) < COLS);
    assign out_data  = out_valid ? acc[row] : '0;
    assign out_row   = row;
    assign out_last  = out_valid && (row == ROW_LAST);

    // One product unit per row, all fed by the current column's coefficients.
    for (genvar r = 0; r < ROWS; r++) begin : g_apply
        fec_coeff_apply #(.W(W)) u_apply (
            .mask   (coeff[r][col]),
            .symbol (in_data),
            .result (prod[r])
        );
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (rst) state <= IDLE;
        else     state <= next_state;
    end

    // Frame sequencing: collect COLS beats, then drain ROWS results.
    always_comb begin
        next_state = state;
        unique case (state)
            IDLE:    if (in_fire) next_state = (COLS == 1) ? DRAIN : ACCUM;
            ACCUM:   if (in_fire && (col == COL_LAST)) next_state = DRAIN;
            DRAIN:   if (out_fire && (row == ROW_LAST)) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Column and row counters, each wrapping at the end of its phase.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            col <= '0;
            row <= '0;
        end else begin
            if (in_fire)  col <= (col == COL_LAST) ? '0 : col + 1'b1;
            if (out_fire) row <= (row == ROW_LAST) ? '0 : row + 1'b1;
        end
    end

    // Accumulators: first beat of a frame loads, later beats XOR in.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            // NOTE: this small register array is reset so a restarted block never exposes stale results.
            for (int r = 0; r < ROWS; r++) acc[r] <= '0;
        end else if (in_fire) begin
            for (int r = 0; r < ROWS; r++) begin
                acc[r] <= (col == '0) ? prod[r] : (acc[r] ^ prod[r]);
            end
        end
    end

`ifdef FEC_COEFF_SHADOW_EN
    logic [W-1:0] shadow [ROWS][COLS];
    logic         pending;
    logic         commit_copy;

    assign cfg_ready   = 1'b1;
    assign commit_copy = pending && (state == IDLE) && !in_fire;

    // Shadow bank takes every in-range write immediately.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int r = 0; r < ROWS; r++)
                for (int c = 0; c < COLS; c++) shadow[r][c] <= '0;
        end else if (cfg_hit) begin
            shadow[cfg_row][cfg_col] <= cfg_coeff;
        end
    end

    // Active bank copies the shadow only between frames; a commit arriving on the copy cycle re-arms.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pending <= 1'b0;
            for (int r = 0; r < ROWS; r++)
                for (int c = 0; c < COLS; c++) coeff[r][c] <= '0;
        end else begin
            pending <= cfg_commit || (pending && !commit_copy);
            if (commit_copy) coeff <= shadow;
        end
    end
`else
    logic cfg_commit_unused;
    assign cfg_commit_unused = cfg_commit;

    // An input beat has priority over a config write, keeping the bank frozen during a frame.
    assign cfg_ready = (state == IDLE) && !in_valid;

    // Single coefficient bank written directly while idle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int r = 0; r < ROWS; r++)
                for (int c = 0; c < COLS; c++) coeff[r][c] <= '0;
        end else if (cfg_hit && cfg_ready) begin
            coeff[cfg_row][cfg_col] <= cfg_coeff;
        end
    end
`endif

endmodule

// File: tb/tb_fec_matrix_stream.sv
// Scoreboard bench for fec_matrix_stream; honours FEC_COEFF_SHADOW_EN when defined.
// The reference model treats each coefficient as a polynomial and reduces the
// carry-less product modulo x^W - 1.
module tb_fec_matrix_stream;

    localparam int ROWS = 3;
    localparam int COLS = 3;
    localparam int W    = 11;
    localparam int RW   = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int CW   = (COLS > 1) ? $clog2(COLS) : 1;

    typedef struct {
        logic [W-1:0]  data;
        logic [RW-1:0] row;
        logic          last;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          cfg_we = 1'b0;
    logic          cfg_ready;
    logic [RW-1:0] cfg_row = '0;
    logic [CW-1:0] cfg_col = '0;
    logic [W-1:0]  cfg_coeff = '0;
    logic          cfg_commit = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [W-1:0]  in_data = '0;
    logic          out_valid;
    logic          out_ready = 1'b1;
    logic [W-1:0]  out_data;
    logic [RW-1:0] out_row;
    logic          out_last;

    exp_t          sb[$];
    int            total = 0;
    int            bad   = 0;
    int            bp_mode = 0;
    logic [W-1:0]  m_coef   [ROWS][COLS];
    logic [W-1:0]  m_shadow [ROWS][COLS];

    fec_matrix_stream #(.ROWS(ROWS), .COLS(COLS), .W(W)) dut (
        .clk        (clk),
        .rst        (rst),
        .cfg_we     (cfg_we),
        .cfg_ready  (cfg_ready),
        .cfg_row    (cfg_row),
        .cfg_col    (cfg_col),
        .cfg_coeff  (cfg_coeff),
        .cfg_commit (cfg_commit),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_row    (out_row),
        .out_last   (out_last)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Output backpressure: 0 always ready, 1 always stalled, 2 random.
    always @(posedge clk) begin
        #1;
        case (bp_mode)
            0:       out_ready = 1'b1;
            1:       out_ready = 1'b0;
            default: out_ready = ($urandom_range(0, 3) != 0);
        endcase
    end

    // Monitor: every output handshake is compared with the scoreboard head.
    always @(negedge clk) begin
        exp_t e;
        if (!rst && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_output: got row %0d data 0x%0h with nothing expected", out_row, out_data);
            end else begin
                e = sb.pop_front();
                check("out_data", 32'(out_data), 32'(e.data));
                check("out_row",  32'(out_row),  32'(e.row));
                check("out_last", 32'(out_last), 32'(e.last));
            end
        end
    end

    // Polynomial product a(x)*s(x) mod x^W - 1 after the complement rule.
    function automatic logic [W-1:0] model_apply(input logic [W-1:0] m, input logic [W-1:0] s);
        logic [W-1:0] a;
        logic [W-1:0] r;
        if (m == '0) return '0;
        a = ($countones(m) > (W - 1) / 2) ? ~m : m;
        r = '0;
        for (int i = 0; i < W; i++)
            for (int j = 0; j < W; j++)
                if (a[i] && s[j]) r[(i + j) % W] = r[(i + j) % W] ^ 1'b1;
        return r;
    endfunction

    task automatic push_exp(input int r, input logic [W-1:0] d);
        exp_t e;
        e.data = d;
        e.row  = RW'(r);
        e.last = (r == ROWS - 1);
        sb.push_back(e);
    endtask

    task automatic push_model(input logic [W-1:0] d [COLS]);
        logic [W-1:0] acc;
        for (int r = 0; r < ROWS; r++) begin
            acc = '0;
            for (int c = 0; c < COLS; c++) acc ^= model_apply(m_coef[r][c], d[c]);
            push_exp(r, acc);
        end
    endtask

    task automatic send_beat(input logic [W-1:0] d);
        logic ok;
        int   n;
        in_valid = 1'b1;
        in_data  = d;
        n = 0;
        do begin
            @(negedge clk);
            ok = in_ready;
            @(posedge clk);
            #1;
            n++;
        end while (!ok && n < 200);
        if (!ok) begin
            total++;
            bad++;
            $display("FAIL in_timeout: got no in_ready within 200 cycles, required acceptance");
        end
        in_valid = 1'b0;
    endtask

    task automatic send_frame(input logic [W-1:0] d [COLS], input int max_gap);
        for (int c = 0; c < COLS; c++) begin
            repeat ($urandom_range(0, max_gap)) @(posedge clk);
            #1;
            send_beat(d[c]);
        end
    endtask

    task automatic cfg_write(input int r, input int c, input logic [W-1:0] v);
        logic ok;
        int   n;
        cfg_we    = 1'b1;
        cfg_row   = RW'(r);
        cfg_col   = CW'(c);
        cfg_coeff = v;
        n = 0;
        do begin
            @(negedge clk);
            ok = cfg_ready;
            @(posedge clk);
            #1;
            n++;
        end while (!ok && n < 200);
        cfg_we = 1'b0;
        if (!ok) begin
            total++;
            bad++;
            $display("FAIL cfg_timeout: got no cfg_ready within 200 cycles, required acceptance");
        end else if (r < ROWS && c < COLS) begin
`ifdef FEC_COEFF_SHADOW_EN
            m_shadow[r][c] = v;
`else
            m_coef[r][c] = v;
`endif
        end
    endtask

    task automatic cfg_apply();
`ifdef FEC_COEFF_SHADOW_EN
        cfg_commit = 1'b1;
        @(posedge clk);
        #1;
        cfg_commit = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        m_coef = m_shadow;
`endif
    endtask

    task automatic wait_empty();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 500) begin
            @(posedge clk);
            n++;
        end
        if (sb.size() != 0) begin
            total++;
            bad++;
            $display("FAIL drain_timeout: got %0d results still pending, required 0", sb.size());
            sb.delete();
        end
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_cfg_ready"}, 32'(cfg_ready), 32'd1);
        check({tag, "_in_ready"},  32'(in_ready),  32'd1);
        check({tag, "_out_valid"}, 32'(out_valid), 32'd0);
        check({tag, "_out_data"},  32'(out_data),  32'd0);
        check({tag, "_out_row"},   32'(out_row),   32'd0);
        check({tag, "_out_last"},  32'(out_last),  32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got simulation still running, required completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [W-1:0] d [COLS];
        logic [W-1:0] v;

        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++) begin
                m_coef[r][c]   = '0;
                m_shadow[r][c] = '0;
            end

        // Reset state.
        #12;
        check_reset_outputs("rst");
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Identity coefficients with latency check.
        cfg_write(0, 0, 11'h001);
        cfg_write(1, 1, 11'h001);
        cfg_write(2, 2, 11'h001);
        cfg_apply();
        push_exp(0, 11'h005);
        push_exp(1, 11'h0A0);
        push_exp(2, 11'h7FF);
        send_beat(11'h005);
        send_beat(11'h0A0);
        check("lat_before_last", 32'(out_valid), 32'd0);
        send_beat(11'h7FF);
        check("lat_out_valid", 32'(out_valid), 32'd1);
        check("lat_in_ready",  32'(in_ready),  32'd0);
        wait_empty();

        // Rotation wrap across the top bit.
        cfg_write(1, 1, 11'h000);
        cfg_write(2, 2, 11'h000);
        cfg_write(0, 0, 11'h002);
        cfg_apply();
        push_exp(0, 11'h003);
        push_exp(1, 11'h000);
        push_exp(2, 11'h000);
        d = '{11'h401, 11'h000, 11'h000};
        send_frame(d, 0);
        wait_empty();

        // Complement rule: dense mask behaves as its sparse complement.
        cfg_write(0, 0, 11'h7FE);
        cfg_apply();
        push_exp(0, 11'h123);
        push_exp(1, 11'h000);
        push_exp(2, 11'h000);
        d = '{11'h123, 11'h000, 11'h000};
        send_frame(d, 0);
        wait_empty();

        // Backpressure: results must hold while stalled.
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++) cfg_write(r, c, W'($urandom));
        cfg_apply();
        bp_mode = 1;
        @(posedge clk);
        #1;
        for (int c = 0; c < COLS; c++) d[c] = W'($urandom);
        push_model(d);
        send_frame(d, 0);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check("bp_out_valid", 32'(out_valid), 32'd1);
            check("bp_out_data",  32'(out_data),  32'(sb[0].data));
            check("bp_out_row",   32'(out_row),   32'd0);
            check("bp_in_ready",  32'(in_ready),  32'd0);
        end
        bp_mode = 0;
        wait_empty();

        // Reset mid-frame discards partial accumulation and the bank.
        send_beat(W'($urandom));
        send_beat(W'($urandom));
        rst = 1'b1;
        #1;
        check_reset_outputs("mid_rst");
        @(posedge clk);
        #1;
        rst = 1'b0;
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++) begin
                m_coef[r][c]   = '0;
                m_shadow[r][c] = '0;
            end
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++) cfg_write(r, c, 11'h001);
        cfg_apply();
        for (int r = 0; r < ROWS; r++) push_exp(r, 11'h001);
        d = '{11'h001, 11'h001, 11'h001};
        send_frame(d, 0);
        wait_empty();

        // Config gating during a frame.
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++) cfg_write(r, c, W'($urandom_range(1, 200)));
        cfg_apply();
        for (int c = 0; c < COLS; c++) d[c] = W'($urandom_range(1, 2047));
        push_model(d);
        send_beat(d[0]);
        v = m_coef[0][1] ^ 11'h155;
`ifdef FEC_COEFF_SHADOW_EN
        cfg_we    = 1'b1;
        cfg_row   = RW'(0);
        cfg_col   = CW'(1);
        cfg_coeff = v;
        cfg_commit = 1'b1;
        @(negedge clk);
        check("gate_cfg_ready", 32'(cfg_ready), 32'd1);
        @(posedge clk);
        #1;
        cfg_we     = 1'b0;
        cfg_commit = 1'b0;
        m_shadow[0][1] = v;
`else
        cfg_we    = 1'b1;
        cfg_row   = RW'(0);
        cfg_col   = CW'(1);
        cfg_coeff = v;
        @(negedge clk);
        check("gate_cfg_ready", 32'(cfg_ready), 32'd0);
        @(posedge clk);
        #1;
        cfg_we = 1'b0;
`endif
        for (int c = 1; c < COLS; c++) send_beat(d[c]);
        wait_empty();
`ifdef FEC_COEFF_SHADOW_EN
        repeat (2) @(posedge clk);
        #1;
        m_coef = m_shadow;
`endif
        for (int c = 0; c < COLS; c++) d[c] = W'($urandom_range(1, 2047));
        push_model(d);
        send_frame(d, 1);
        wait_empty();

        // Out-of-range writes are acknowledged and dropped.
        cfg_write(ROWS, 0, 11'h7AB);
        cfg_write(0, COLS, 11'h3CD);
        cfg_apply();
        for (int c = 0; c < COLS; c++) d[c] = W'($urandom);
        push_model(d);
        send_frame(d, 0);
        wait_empty();

        // Randomised frames with random backpressure and config churn.
        bp_mode = 2;
        for (int f = 0; f < 25; f++) begin
            repeat ($urandom_range(0, 3)) cfg_write($urandom_range(0, 3), $urandom_range(0, 3), W'($urandom));
            cfg_apply();
            for (int c = 0; c < COLS; c++) begin
                case ($urandom_range(0, 5))
                    0:       d[c] = '0;
                    1:       d[c] = '1;
                    default: d[c] = W'($urandom);
                endcase
            end
            push_model(d);
            send_frame(d, 2);
            wait_empty();
        end
        bp_mode = 0;

        check("sb_drained", 32'(sb.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
